// File: rtl/axis_pixel_packer_if.sv
// Stream bundle around the pixel packer: the single-pixel input stream
// and the packed multi-pixel output stream.
// The slave modport is the packer's own view. The master modport is the
// view of the surrounding logic (pixel source plus beat sink).
interface axis_pixel_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
);
  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic [DATA_WIDTH-1:0]       s_axis_tdata;
  logic                        s_axis_tlast;
  logic                        s_axis_tuser;

  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic [DATA_WIDTH*RATIO-1:0] m_axis_tdata;
  logic [RATIO-1:0]            m_axis_tkeep;
  logic                        m_axis_tlast;
  logic                        m_axis_tuser;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
           m_axis_tlast, m_axis_tuser
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
           m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/axis_pixel_packer.sv
// Packs RATIO consecutive pixels of a single-pixel AXI4-Stream into one
// wide little-endian beat with tkeep, splits words at end of line and at
// an unexpected start of frame, and checks every line length against
// IMG_WIDTH.
module axis_pixel_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int IMG_WIDTH  = 640
) (
  input  logic               aclk,
  input  logic               areset,
  axis_pixel_packer_if.slave bus,
  output logic               line_len_err,
  output logic               sof_err
);

  localparam int LANE_W = $clog2(RATIO);
  localparam int CNT_W  = $clog2(IMG_WIDTH + 2);

  typedef logic [RATIO-1:0][DATA_WIDTH-1:0] word_t;

  // ST_FLUSH: a start-of-frame pixel that also ended its line sits alone in
  // the accumulator and must be emitted before more input is taken.
  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t            state_q, state_d;
  word_t             acc_q, acc_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              acc_user_q, acc_user_d;

  logic              out_valid_q;
  word_t             out_data_q;
  logic [RATIO-1:0]  out_keep_q;
  logic              out_last_q;
  logic              out_user_q;

  logic              load;
  word_t             load_data;
  logic [RATIO-1:0]  load_keep;
  logic              load_last;
  logic              load_user;

  logic              out_free;
  logic              s_ready;
  logic              accept;
  logic              sof_split;
  logic              word_done;
  word_t             merged;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_incl;

  // Handshake decode, accumulator update and word hand-off to the output.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    lane_d     = lane_q;
    acc_user_d = acc_user_q;
    load       = 1'b0;
    load_data  = '0;
    load_keep  = '0;
    load_last  = 1'b0;
    load_user  = 1'b0;

    merged         = acc_q;
    merged[lane_q] = bus.s_axis_tdata;

    // tready depends only on registered state and the downstream ready.
    out_free  = !out_valid_q || bus.m_axis_tready;
    s_ready   = out_free && (state_q == ST_RUN);
    accept    = bus.s_axis_tvalid && s_ready;
    sof_split = accept && bus.s_axis_tuser && (lane_q != '0);
    word_done = accept && !sof_split &&
                ((lane_q == LANE_W'(RATIO - 1)) || bus.s_axis_tlast);

    case (state_q)
      ST_FLUSH: begin
        if (out_free) begin
          load       = 1'b1;
          load_data  = acc_q;
          load_keep  = RATIO'(1);
          load_last  = 1'b1;
          load_user  = acc_user_q;
          acc_d      = '0;
          acc_user_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        if (sof_split) begin
          // Close the pending partial word as a line end, restart at lane 0.
          load      = 1'b1;
          load_data = acc_q;
          for (int k = 0; k < RATIO; k++) load_keep[k] = (k < int'(lane_q));
          load_last  = 1'b1;
          load_user  = acc_user_q;
          acc_d      = '0;
          acc_d[0]   = bus.s_axis_tdata;
          acc_user_d = 1'b1;
          if (bus.s_axis_tlast) begin
            lane_d  = '0;
            state_d = ST_FLUSH;
          end else begin
            lane_d = LANE_W'(1);
          end
        end else if (word_done) begin
          load      = 1'b1;
          load_data = merged;
          for (int k = 0; k < RATIO; k++) load_keep[k] = (k <= int'(lane_q));
          load_last  = bus.s_axis_tlast;
          load_user  = acc_user_q | bus.s_axis_tuser;
          acc_d      = '0;
          lane_d     = '0;
          acc_user_d = 1'b0;
        end else if (accept) begin
          acc_d      = merged;
          lane_d     = lane_q + LANE_W'(1);
          acc_user_d = acc_user_q | bus.s_axis_tuser;
        end
      end
    endcase
  end

  // Line length including the pixel on the input, saturating above IMG_WIDTH.
  always_comb begin
    cnt_incl = cnt_q;
    if (bus.s_axis_tuser)                        cnt_incl = CNT_W'(1);
    else if (cnt_q != CNT_W'(IMG_WIDTH + 1))     cnt_incl = cnt_q + CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and updates together.
    if (areset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Accumulator, lane index and merged tuser of the word being built.
  always_ff @(posedge aclk) begin
    if (areset) begin
      acc_q      <= '0;
      lane_q     <= '0;
      acc_user_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      lane_q     <= lane_d;
      acc_user_q <= acc_user_d;
    end
  end

  // Output register: load a finished word, hold while stalled, drop on handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= load_data;
      out_keep_q  <= load_keep;
      out_last_q  <= load_last;
      out_user_q  <= load_user;
    end else if (bus.m_axis_tready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Pixel counter and the one-cycle error pulses.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q        <= '0;
      line_len_err <= 1'b0;
      sof_err      <= 1'b0;
    end else begin
      line_len_err <= 1'b0;
      sof_err      <= sof_split;
      if (accept) begin
        if (bus.s_axis_tlast) begin
          line_len_err <= (cnt_incl != CNT_W'(IMG_WIDTH));
          cnt_q        <= '0;
        end else begin
          cnt_q <= cnt_incl;
        end
      end
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = out_valid_q;
  assign bus.m_axis_tdata  = out_data_q;
  assign bus.m_axis_tkeep  = out_keep_q;
  assign bus.m_axis_tlast  = out_last_q;
  assign bus.m_axis_tuser  = out_user_q;

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Bench for axis_pixel_packer: a queue-based packing model predicts every
// output beat and error pulse from the accepted input pixels; directed
// scenarios pin the model with literal beats.
module tb_axis_pixel_packer;

  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int IMG   = 640;

  typedef struct packed {
    logic [DW*RATIO-1:0] data;
    logic [RATIO-1:0]    keep;
    logic                last;
    logic                user;
  } beat_t;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  logic line_len_err;
  logic sof_err;

  axis_pixel_packer_if #(.DATA_WIDTH(DW), .RATIO(RATIO)) bus ();

  axis_pixel_packer #(.DATA_WIDTH(DW), .RATIO(RATIO), .IMG_WIDTH(IMG)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .bus          (bus),
    .line_len_err (line_len_err),
    .sof_err      (sof_err)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // Model state.
  beat_t      exp_q[$];
  beat_t      got_q[$];
  logic [7:0] pend[$];
  logic       pend_user   = 1'b0;
  int         line_len    = 0;
  logic       exp_len_err = 1'b0;
  logic       exp_sof_err = 1'b0;

  // Observed event counters.
  int len_err_cnt = 0;
  int sof_err_cnt = 0;
  int stall_cnt   = 0;

  int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  logic mon_en     = 1'b0;
  logic hold_prev  = 1'b0;
  beat_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void emit(input logic last);
    beat_t b;
    b = '0;
    for (int i = 0; i < pend.size(); i++) begin
      b.data[i*DW +: DW] = pend[i];
      b.keep[i]          = 1'b1;
    end
    b.last = last;
    b.user = pend_user;
    exp_q.push_back(b);
    pend.delete();
    pend_user = 1'b0;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic l, input logic u);
    exp_sof_err = u && (pend.size() > 0);
    if (exp_sof_err) emit(1'b1);
    pend.push_back(d);
    pend_user = pend_user | u;
    if (pend.size() == RATIO || l) emit(l);
    line_len = u ? 1 : line_len + 1;
    if (l) begin
      exp_len_err = (line_len != IMG);
      line_len    = 0;
    end
  endfunction

  // Compare process: error pulses, beats, hold stability and the ready rule.
  always @(negedge aclk) begin
    if (mon_en) begin
      beat_t cur;
      cur = '{bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tuser};
      check("line_len_err", line_len_err, exp_len_err);
      check("sof_err", sof_err, exp_sof_err);
      exp_len_err = 1'b0;
      exp_sof_err = 1'b0;
      len_err_cnt += int'(line_len_err);
      sof_err_cnt += int'(sof_err);
      if (hold_prev) begin
        check("hold_valid", bus.m_axis_tvalid, 1'b1);
        check("hold_beat", cur, held);
      end
      if (bus.m_axis_tvalid && !bus.m_axis_tready)
        check("tready_when_full", bus.s_axis_tready, 1'b0);
      if (bus.s_axis_tvalid && !bus.s_axis_tready) stall_cnt++;
      if (areset) begin
        exp_q.delete();
        pend.delete();
        pend_user = 1'b0;
        line_len  = 0;
        hold_prev = 1'b0;
      end else begin
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          got_q.push_back(cur);
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1'b1, 1'b0);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", cur.data, e.data);
            check("beat_keep", cur.keep, e.keep);
            check("beat_last", cur.last, e.last);
            check("beat_user", cur.user, e.user);
          end
        end
        if (bus.s_axis_tvalid && bus.s_axis_tready)
          model_accept(bus.s_axis_tdata, bus.s_axis_tlast, bus.s_axis_tuser);
        hold_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
        held      = cur;
      end
    end
  end

  // Downstream ready driver.
  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
        default: bus.m_axis_tready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [7:0] d, input logic l, input logic u);
    logic acc;
    int   guard;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tuser  = u;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge aclk);
      acc = bus.s_axis_tready;
      @(posedge aclk);
      #1;
      guard++;
    end
    if (!acc) begin
      check("send_timeout", 1'b0, 1'b1);
      bus.s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bus.s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic set_ready(input int mode);
    @(negedge aclk);
    ready_mode = mode;
    @(posedge aclk);
    #1;
  endtask

  task automatic check_beat(input string name, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l, input logic u);
    if (idx >= got_q.size()) begin
      check({name, "_missing"}, 1'b0, 1'b1);
    end else begin
      check({name, "_data"}, got_q[idx].data, d);
      check({name, "_keep"}, got_q[idx].keep, k);
      check({name, "_last"}, got_q[idx].last, l);
      check({name, "_user"}, got_q[idx].user, u);
    end
  endtask

  task automatic do_reset_and_check(input string name);
    bus.s_axis_tvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check({name, "_tvalid"}, bus.m_axis_tvalid, 1'b0);
    check({name, "_tdata"}, bus.m_axis_tdata, '0);
    check({name, "_tkeep"}, bus.m_axis_tkeep, '0);
    check({name, "_tlast"}, bus.m_axis_tlast, 1'b0);
    check({name, "_tuser"}, bus.m_axis_tuser, 1'b0);
    check({name, "_len_err"}, line_len_err, 1'b0);
    check({name, "_sof_err"}, sof_err, 1'b0);
    areset = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    bus.s_axis_tvalid = 1'b0;
    while ((exp_q.size() != 0 || bus.m_axis_tvalid) && guard < 100) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    idle(2);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int base, len0, sof0, st0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;

    @(posedge aclk);
    #1;
    mon_en = 1'b1;
    do_reset_and_check("reset_init");
    idle(2);

    // Eight pixels, two full beats, wrong line length.
    base = got_q.size(); len0 = len_err_cnt;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), i == 8, 1'b0);
      if (i == 4) begin
        check("latency_valid", bus.m_axis_tvalid, 1'b1);
        check("latency_data", bus.m_axis_tdata, 32'h0403_0201);
      end
    end
    drain("t1");
    check_beat("t1_b0", base,     32'h0403_0201, 4'hF, 1'b0, 1'b0);
    check_beat("t1_b1", base + 1, 32'h0807_0605, 4'hF, 1'b1, 1'b0);
    check("t1_len_err_pulses", len_err_cnt - len0, 1);

    // Full-width line at full rate.
    base = got_q.size(); len0 = len_err_cnt; sof0 = sof_err_cnt; st0 = stall_cnt;
    for (int i = 0; i < IMG; i++) send(8'(i), i == IMG - 1, i == 0);
    drain("t2");
    check("t2_beats", got_q.size() - base, 160);
    check_beat("t2_first", base, 32'h0302_0100, 4'hF, 1'b0, 1'b1);
    check_beat("t2_final", base + 159, 32'h7F7E_7D7C, 4'hF, 1'b1, 1'b0);
    check("t2_len_err", len_err_cnt - len0, 0);
    check("t2_sof_err", sof_err_cnt - sof0, 0);
    check("t2_stalls", stall_cnt - st0, 0);

    // Six-pixel line: short final beat.
    base = got_q.size(); len0 = len_err_cnt;
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i == 5, 1'b0);
    drain("t3");
    check_beat("t3_b0", base,     32'hA3A2_A1A0, 4'hF, 1'b0, 1'b0);
    check_beat("t3_b1", base + 1, 32'h0000_A5A4, 4'h3, 1'b1, 1'b0);
    check("t3_len_err", len_err_cnt - len0, 1);

    // Ten-cycle downstream stall mid-line.
    base = got_q.size(); st0 = stall_cnt;
    fork
      begin
        for (int i = 0; i < 12; i++) send(8'h10 + 8'(i), i == 11, 1'b0);
      end
      begin
        repeat (2) @(negedge aclk);
        ready_mode = 2;
        repeat (10) @(negedge aclk);
        ready_mode = 0;
      end
    join
    drain("t4");
    check("t4_stall_seen", (stall_cnt - st0) >= 5, 1'b1);
    check("t4_beats", got_q.size() - base, 3);
    check_beat("t4_b0", base,     32'h1312_1110, 4'hF, 1'b0, 1'b0);
    check_beat("t4_b1", base + 1, 32'h1716_1514, 4'hF, 1'b0, 1'b0);
    check_beat("t4_b2", base + 2, 32'h1B1A_1918, 4'hF, 1'b1, 1'b0);

    // Start of frame with a partial word pending, then with tlast on it.
    base = got_q.size(); len0 = len_err_cnt; sof0 = sof_err_cnt;
    send(8'h30, 1'b0, 1'b0);
    send(8'h31, 1'b0, 1'b0);
    send(8'h40, 1'b0, 1'b1);
    send(8'h41, 1'b0, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    send(8'h43, 1'b0, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    send(8'h50, 1'b0, 1'b0);
    send(8'h60, 1'b1, 1'b1);
    send(8'h61, 1'b0, 1'b0);
    send(8'h62, 1'b1, 1'b0);
    drain("t5");
    check_beat("t5_partial", base,     32'h0000_3130, 4'h3, 1'b1, 1'b0);
    check_beat("t5_sofword", base + 1, 32'h4342_4140, 4'hF, 1'b0, 1'b1);
    check_beat("t5_tail",    base + 2, 32'h0000_0044, 4'h1, 1'b1, 1'b0);
    check_beat("t5_part2",   base + 3, 32'h0000_0050, 4'h1, 1'b1, 1'b0);
    check_beat("t5_single",  base + 4, 32'h0000_0060, 4'h1, 1'b1, 1'b1);
    check_beat("t5_after",   base + 5, 32'h0000_6261, 4'h3, 1'b1, 1'b0);
    check("t5_sof_err", sof_err_cnt - sof0, 2);
    check("t5_len_err", len_err_cnt - len0, 3);

    // Reset with pixels pending, then with a held output beat.
    set_ready(2);
    send(8'h70, 1'b0, 1'b0);
    send(8'h71, 1'b0, 1'b0);
    send(8'h72, 1'b0, 1'b0);
    do_reset_and_check("reset_pending");
    send(8'h80, 1'b0, 1'b0);
    send(8'h81, 1'b1, 1'b0);
    check("t6_held_valid", bus.m_axis_tvalid, 1'b1);
    do_reset_and_check("reset_held");
    set_ready(0);
    base = got_q.size();
    for (int i = 0; i < 4; i++) send(8'h90 + 8'(i), 1'b0, 1'b0);
    drain("t6");
    check_beat("t6_post_reset", base, 32'h9392_9190, 4'hF, 1'b0, 1'b0);

    // Random traffic with random downstream backpressure.
    set_ready(1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    set_ready(0);
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
